// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with registered status flags and sticky overflow/underflow errors; pops return data
// one cycle later, or zero-latency first-word-fall-through when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_ctrl #(
    parameter int DATASIZE   = 8,
    parameter int ADDRSIZE   = 4,
    parameter int AFULL_LVL  = (1 << ADDRSIZE) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rd_en,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                full,
    output logic                empty,
    output logic                afull,
    output logic                aempty,
    output logic [ADDRSIZE:0]   count,
    output logic                ovf,
    output logic                udf,
    input  logic                err_clr
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_W  = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AFULL_W  = (ADDRSIZE+1)'(AFULL_LVL);
    localparam logic [ADDRSIZE:0] AEMPTY_W = (ADDRSIZE+1)'(AEMPTY_LVL);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [ADDRSIZE-1:0] wr_ptr;
    logic [ADDRSIZE-1:0] rd_ptr;
    logic [ADDRSIZE:0]   count_nxt;
    logic                push_acc;
    logic                pop_acc;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it.
    assign pop_acc  = rd_en && !empty;
    assign push_acc = wr_en && (!full || pop_acc);

    always_comb begin
        count_nxt = count;
        if (push_acc && !pop_acc)
            count_nxt = count + (ADDRSIZE+1)'(1);
        else if (pop_acc && !push_acc)
            count_nxt = count - (ADDRSIZE+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_acc)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + ADDRSIZE'(1);
            if (pop_acc)
                rd_ptr <= rd_ptr + ADDRSIZE'(1);
            count  <= count_nxt;
            full   <= (count_nxt == DEPTH_W);
            empty  <= (count_nxt == '0);
            afull  <= (count_nxt >= AFULL_W);
            aempty <= (count_nxt <= AEMPTY_W);
            // Clearing wins over a same-cycle error so software never loses the clear.
            if (err_clr)
                ovf <= 1'b0;
            else if (wr_en && !push_acc)
                ovf <= 1'b1;
            if (err_clr)
                udf <= 1'b0;
            else if (rd_en && empty)
                udf <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is masked while empty so stale array contents never leak out.
    assign rdata  = empty ? '0 : mem[rd_ptr];
    assign rvalid = !empty;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= pop_acc;
            if (pop_acc)
                rdata <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl at default parameters (DEPTH 16, afull 14, aempty 2).
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic [7:0] rdata;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic       afull;
    logic       aempty;
    logic [4:0] count;
    logic       ovf;
    logic       udf;
    logic       err_clr;

    int vectors = 0;
    int miscompares = 0;

    sync_fifo_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .rd_en   (rd_en),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .full    (full),
        .empty   (empty),
        .afull   (afull),
        .aempty  (aempty),
        .count   (count),
        .ovf     (ovf),
        .udf     (udf),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; err_clr = 1'b0; wdata = 8'hEE;
        tick(); tick();
        vectors++;
        if (count !== 5'd0) begin
            miscompares++; $display("FAIL reset_count got %0d want 0", count);
        end
        vectors++;
        if ({full, empty, afull, aempty, ovf, udf, rvalid} !== 7'b0101000) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 0101000", {full, empty, afull, aempty, ovf, udf, rvalid});
        end
        vectors++;
        if (rdata !== 8'h00) begin
            miscompares++; $display("FAIL reset_rdata got %h want 00", rdata);
        end
        wr_en = 1'b0; rd_en = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] d [3];
        d = '{8'hA1, 8'hB2, 8'hC3};
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wdata = d[i];
            tick();
            vectors++;
            if (count !== 5'(i + 1)) begin
                miscompares++; $display("FAIL basic_push_count got %0d want %0d", count, i + 1);
            end
        end
        wr_en = 1'b0;
        vectors++;
        if ({empty, aempty, rvalid} !== 3'b000) begin
            miscompares++; $display("FAIL basic_flags3 got %b want 000", {empty, aempty, rvalid});
        end
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            tick();
            vectors++;
            if (rvalid !== 1'b1 || rdata !== d[i] || count !== 5'(2 - i)) begin
                miscompares++;
                $display("FAIL basic_pop%0d got rvalid=%b rdata=%h count=%0d want 1 %h %0d",
                         i, rvalid, rdata, count, d[i], 2 - i);
            end
        end
        rd_en = 1'b0;
        tick();
        vectors++;
        if (rvalid !== 1'b0 || rdata !== 8'hC3 || empty !== 1'b1 || aempty !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_idle got rvalid=%b rdata=%h empty=%b aempty=%b want 0 c3 1 1",
                     rvalid, rdata, empty, aempty);
        end
    endtask

    task automatic test_fill();
        logic exp_af, exp_full;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wdata = 8'(8'h10 + i);
            tick();
            exp_af   = (i + 1 >= 14);
            exp_full = (i + 1 == 16);
            vectors++;
            if (count !== 5'(i + 1) || afull !== exp_af || full !== exp_full) begin
                miscompares++;
                $display("FAIL fill%0d got count=%0d afull=%b full=%b want %0d %b %b",
                         i, count, afull, full, i + 1, exp_af, exp_full);
            end
        end
        wdata = 8'hEE;
        tick();
        wr_en = 1'b0;
        vectors++;
        if (ovf !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow got ovf=%b count=%0d full=%b want 1 16 1", ovf, count, full);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++; $display("FAIL ovf_clear got %b want 0", ovf);
        end
    endtask

    task automatic test_full_simul();
        logic [7:0] exp_d;
        wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h55;
        tick();
        wr_en = 1'b0;
        vectors++;
        if (count !== 5'd16 || ovf !== 1'b0 || full !== 1'b1 || rvalid !== 1'b1 || rdata !== 8'h10) begin
            miscompares++;
            $display("FAIL full_simul got count=%0d ovf=%b full=%b rvalid=%b rdata=%h want 16 0 1 1 10",
                     count, ovf, full, rvalid, rdata);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_d = (i < 15) ? 8'(8'h11 + i) : 8'h55;
            vectors++;
            if (rdata !== exp_d || rvalid !== 1'b1) begin
                miscompares++;
                $display("FAIL drain%0d got rdata=%h rvalid=%b want %h 1", i, rdata, rvalid, exp_d);
            end
        end
        rd_en = 1'b0;
        tick();
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || afull !== 1'b0) begin
            miscompares++;
            $display("FAIL drained got count=%0d empty=%b full=%b afull=%b want 0 1 0 0", count, empty, full, afull);
        end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++;
        if (udf !== 1'b1 || rvalid !== 1'b0) begin
            miscompares++; $display("FAIL udf_set got udf=%b rvalid=%b want 1 0", udf, rvalid);
        end
        err_clr = 1'b1;
        tick();
        vectors++;
        if (udf !== 1'b0) begin
            miscompares++; $display("FAIL udf_clear got %b want 0", udf);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0; err_clr = 1'b0;
        vectors++;
        if (udf !== 1'b0) begin
            miscompares++; $display("FAIL udf_clr_priority got %b want 0", udf);
        end
        wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h77;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        vectors++;
        if (count !== 5'd1 || udf !== 1'b1 || rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_simul got count=%0d udf=%b rvalid=%b want 1 1 0", count, udf, rvalid);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0; err_clr = 1'b1;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 8'h77 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL empty_simul_pop got rvalid=%b rdata=%h count=%0d want 1 77 0", rvalid, rdata, count);
        end
        tick();
        err_clr = 1'b0;
        vectors++;
        if (udf !== 1'b0) begin
            miscompares++; $display("FAIL udf_final got %b want 0", udf);
        end
    endtask

    task automatic test_stream();
        logic [7:0] d;
        for (int k = 0; k < 40; k++) begin
            d = 8'(k * 7 + 3);
            wr_en = 1'b1; wdata = d;
            tick();
            wr_en = 1'b0;
            vectors++;
            if (count !== 5'd1) begin
                miscompares++; $display("FAIL stream_push%0d got count=%0d want 1", k, count);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            vectors++;
            if (rvalid !== 1'b1 || rdata !== d || count !== 5'd0) begin
                miscompares++;
                $display("FAIL stream_pop%0d got rvalid=%b rdata=%h count=%0d want 1 %h 0", k, rvalid, rdata, count, d);
            end
        end
    endtask

    task automatic test_fwft();
        wr_en = 1'b1; wdata = 8'h3C;
        tick();
        wr_en = 1'b0;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 8'h3C || count !== 5'd1) begin
            miscompares++;
            $display("FAIL fwft_show got rvalid=%b rdata=%h count=%0d want 1 3c 1", rvalid, rdata, count);
        end
        tick();
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 8'h3C) begin
            miscompares++; $display("FAIL fwft_hold got rvalid=%b rdata=%h want 1 3c", rvalid, rdata);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++;
        if (rvalid !== 1'b0 || empty !== 1'b1 || rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL fwft_pop got rvalid=%b empty=%b rdata=%h want 0 1 00", rvalid, empty, rdata);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wdata = 8'(8'h60 + i);
            tick();
        end
        rst_n = 1'b0; wdata = 8'hEE; rd_en = 1'b1; err_clr = 1'b0;
        tick();
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0 || udf !== 1'b0 || rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got count=%0d empty=%b full=%b ovf=%b udf=%b rvalid=%b want 0 1 0 0 0 0",
                     count, empty, full, ovf, udf, rvalid);
        end
        wr_en = 1'b1; wdata = 8'h9A;
        tick();
        wr_en = 1'b0;
        vectors++;
        if (count !== 5'd1) begin
            miscompares++; $display("FAIL reset_mid_push got count=%0d want 1", count);
        end
`ifdef SYNC_FIFO_FWFT_EN
        vectors++;
        if (rdata !== 8'h9A || rvalid !== 1'b1) begin
            miscompares++; $display("FAIL reset_mid_head got rdata=%h rvalid=%b want 9a 1", rdata, rvalid);
        end
`else
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++;
        if (rdata !== 8'h9A || rvalid !== 1'b1 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_pop got rdata=%h rvalid=%b empty=%b want 9a 1 1", rdata, rvalid, empty);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wdata = 8'h00;
        test_reset();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
        test_fill();
`else
        test_basic();
        test_fill();
        test_full_simul();
        test_underflow();
        test_stream();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
